// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO. Bit timing comes from an external
// tx_en strobe; frames are start, LSB-first data, optional parity, then 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          send,
  output logic                          ready,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q;
  logic                 push, pop;

  // ready is derived from the registered count only, so a same-cycle pop never admits a push
  assign ready    = (count_q != CNT_W'(FIFO_DEPTH));
  assign push     = send && ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  assign tx         = tx_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = START;
      START:   if (tx_en) state_d = DATA;
      DATA:    if (tx_en && bit_idx_q == IDX_W'(DATA_BITS - 1))
                 state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tx_en) state_d = STOP;
      STOP:    if (tx_en && stop_cnt_q == 1'(STOP_BITS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: if (pop) begin
        shift_d  = head;
        parity_d = (^head) ^ 1'(PARITY_ODD);
      end
      START: if (tx_en) begin
        tx_d      = 1'b0;
        bit_idx_d = '0;
      end
      DATA: if (tx_en) begin
        tx_d      = shift_q[bit_idx_q];
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
      PARITY: if (tx_en) tx_d = parity_q;
      STOP: if (tx_en) begin
        tx_d       = 1'b1;
        stop_cnt_d = (stop_cnt_q == 1'(STOP_BITS - 1)) ? 1'b0 : ~stop_cnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      overflow_q <= send && !ready;
    end
  end

  // Payload storage carries no reset; the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E2, 8O2, 5N1) share clock, reset and
// the tx_en strobe; expected line levels per strobe are queued and checked by a monitor.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       strobe_on;
  logic [7:0] data0, data1;
  logic [4:0] data3;
  logic       send0, send1, send3;

  logic       ready0, ready1, ready2, ready3;
  logic       overflow0, overflow1, overflow2, overflow3;
  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic [2:0] count0, count1, count2, count3;
  logic [3:0] txv;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  bit expq [4][$];

  assign txv = {tx3, tx2, tx1, tx0};

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .data_in(data0), .send(send0), .ready(ready0),
    .overflow(overflow0), .tx(tx0), .busy(busy0), .fifo_count(count0));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .data_in(data1), .send(send1), .ready(ready1),
    .overflow(overflow1), .tx(tx1), .busy(busy1), .fifo_count(count1));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .data_in(data1), .send(send1), .ready(ready2),
    .overflow(overflow2), .tx(tx2), .busy(busy2), .fifo_count(count2));
  uart_tx_fifo #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .data_in(data3), .send(send3), .ready(ready3),
    .overflow(overflow3), .tx(tx3), .busy(busy3), .fifo_count(count3));

  always #5 clk = ~clk;

  // One-clock strobe every 16 clocks; strobe_on gates it without shifting the phase
  initial begin
    tx_en = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      tx_en = strobe_on;
      @(negedge clk);
      tx_en = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on every strobe each line must show the next queued bit, or idle-high
  always @(posedge clk) begin
    if (tx_en) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        bit e;
        e = 1'b1;
        if (expq[i].size() != 0) e = expq[i].pop_front();
        chk($sformatf("tx%0d_bit", i), 32'(txv[i]), 32'(e));
      end
    end
  end

  always @(negedge clk) if (overflow0 === 1'b1) ovf_cnt++;

  task automatic push_bits(input int i, input logic [15:0] v, input int n);
    for (int b = 0; b < n; b++) expq[i].push_back(v[b]);
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic wait_strobe();
    int c = 0;
    @(posedge clk);
    while (!tx_en && c < 64) begin
      @(posedge clk);
      c++;
    end
    chk("strobe_seen", 32'(tx_en), 32'd1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain", 32'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 32'd0);
  endtask

  initial begin
    int base;
    int c;
    rst_n = 1'b0; strobe_on = 1'b1;
    data0 = '0; data1 = '0; data3 = '0;
    send0 = 1'b0; send1 = 1'b0; send3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx0), 32'd1);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_ovf",   32'(overflow0), 32'd0);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_tx_all", 32'(txv), 32'hF);
    chk("rst_busy_all", 32'({busy3, busy2, busy1}), 32'd0);
    rst_n = 1'b1;

    // 0xA5 on 8N1: start, 1,0,1,0,0,1,0,1, stop
    wait_strobe();
    @(negedge clk); send0 = 1'b1; data0 = 8'hA5;
    push_bits(0, 16'b1101001010, 10);
    @(negedge clk); send0 = 1'b0;
    chk("a5_count1", 32'(count0), 32'd1);
    @(negedge clk);
    chk("a5_count0", 32'(count0), 32'd0);
    chk("a5_busy", 32'(busy0), 32'd1);
    wait_drain();
    chk("a5_busy_fall", 32'(busy0), 32'd0);
    chk("a5_tx_idle", 32'(tx0), 32'd1);

    // 0x07 with even parity (1) and odd parity (0), two stop bits
    wait_strobe();
    @(negedge clk); send1 = 1'b1; data1 = 8'h07;
    push_bits(1, 16'b111000001110, 12);
    push_bits(2, 16'b110000001110, 12);
    @(negedge clk); send1 = 1'b0;
    wait_drain();
    chk("par_busy", 32'({busy2, busy1}), 32'd0);

    // 5-bit frames 0x1F then 0x00 with no idle strobe between them
    wait_strobe();
    @(negedge clk); send3 = 1'b1; data3 = 5'h1F;
    push_bits(3, 16'b1111110, 7);
    push_bits(3, 16'b1000000, 7);
    @(negedge clk); data3 = 5'h00;
    @(negedge clk); send3 = 1'b0;
    wait_drain();
    chk("d5_busy", 32'(busy3), 32'd0);

    // Overflow: one frame in flight, strobes stalled, send held for 6 cycles
    wait_strobe();
    @(negedge clk); send0 = 1'b1; data0 = 8'h11; strobe_on = 1'b0;
    @(negedge clk); send0 = 1'b0;
    @(negedge clk);
    base = ovf_cnt;
    for (int k = 0; k < 6; k++) begin
      send0 = 1'b1; data0 = 8'h21 + 8'(k);
      @(negedge clk);
    end
    send0 = 1'b0;
    @(negedge clk);
    chk("ovf_pulses", 32'(ovf_cnt - base), 32'd2);
    chk("ovf_ready", 32'(ready0), 32'd0);
    chk("ovf_count", 32'(count0), 32'd4);
    chk("ovf_pulse_end", 32'(overflow0), 32'd0);
    push_bits(0, frame8(8'h11), 10);
    for (int k = 0; k < 4; k++) push_bits(0, frame8(8'h21 + 8'(k)), 10);
    strobe_on = 1'b1;
    wait_drain();
    chk("ovf_ready_back", 32'(ready0), 32'd1);

    // Wrap-around: 10 bytes pushed as fast as ready allows
    base = ovf_cnt;
    wait_strobe();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      c = 0;
      while (!ready0 && c < 5000) begin
        send0 = 1'b0;
        @(negedge clk);
        c++;
      end
      send0 = 1'b1; data0 = 8'(k);
      push_bits(0, frame8(8'(k)), 10);
    end
    @(negedge clk); send0 = 1'b0;
    wait_drain();
    chk("wrap_no_ovf", 32'(ovf_cnt - base), 32'd0);
    chk("wrap_count", 32'(count0), 32'd0);

    // Reset in the middle of 0x3C's data bits with two more bytes queued
    wait_strobe();
    @(negedge clk); send0 = 1'b1; data0 = 8'h3C;
    push_bits(0, frame8(8'h3C), 10);
    push_bits(0, frame8(8'h55), 10);
    push_bits(0, frame8(8'h66), 10);
    @(negedge clk); data0 = 8'h55;
    @(negedge clk); data0 = 8'h66;
    @(negedge clk); send0 = 1'b0;
    repeat (3) wait_strobe();
    @(negedge clk);
    chk("mid_count", 32'(count0), 32'd2);
    chk("mid_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    expq[0].delete();
    #1;
    chk("arst_tx", 32'(tx0), 32'd1);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_count", 32'(count0), 32'd0);
    chk("arst_ready", 32'(ready0), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (48) @(negedge clk);
    chk("post_rst_count", 32'(count0), 32'd0);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    wait_strobe();
    @(negedge clk); send0 = 1'b1; data0 = 8'h81;
    push_bits(0, frame8(8'h81), 10);
    @(negedge clk); send0 = 1'b0;
    wait_drain();
    chk("final_busy", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
